// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches on the memory bus and
// buffers the returned words with their addresses for the decoder, with flush on redirect.
module fetch_queue #(
   parameter int SIZE  = 16,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] RST_VEC,
   input  logic            flush,
   input  logic [SIZE-1:0] flush_addr,
   output logic            fetch_req,
   output logic [SIZE-1:0] fetch_addr,
   input  logic            fetch_en,
   input  logic [SIZE-1:0] MDB_out,
   output logic            instr_valid,
   output logic [SIZE-1:0] instr,
   output logic [SIZE-1:0] instr_pc,
   input  logic            instr_ready,
   output logic [CW-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SIZE-1:0] fpc;
   logic [SIZE-1:0] inflight_addr;
   logic            inflight;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [SIZE-1:0] word_mem [DEPTH];
   logic [SIZE-1:0] addr_mem [DEPTH];
   logic [CW:0]     occupancy;
   logic            issue;
   logic            push;
   logic            pop;

   // The in-flight word holds a slot, so a push can never find the queue full.
   assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign fetch_req  = !rst && !flush && (occupancy < (CW + 1)'(DEPTH));
   assign fetch_addr = fpc;
   assign issue      = fetch_req && fetch_en;
   assign push       = inflight && !flush;
   assign pop        = instr_valid && instr_ready && !flush;

   assign instr_valid = (count != '0);
   assign instr       = word_mem[rd_ptr];
   assign instr_pc    = addr_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc           <= {RST_VEC[SIZE-1:1], 1'b0};
         inflight      <= 1'b0;
         inflight_addr <= '0;
         count         <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
      end else if (flush) begin
         fpc      <= {flush_addr[SIZE-1:1], 1'b0};
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fpc           <= fpc + SIZE'(2);
            inflight_addr <= fpc;
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         word_mem[wr_ptr] <= MDB_out;
         addr_mem[wr_ptr] <= inflight_addr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, with a sequential
// address-stream scoreboard for decoder output and a cycle model for occupancy/bus.
module tb_fetch_queue;

   localparam int SIZE  = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [SIZE-1:0] RST_VEC;
   logic            flush;
   logic [SIZE-1:0] flush_addr;
   logic            fetch_req;
   logic [SIZE-1:0] fetch_addr;
   logic            fetch_en;
   logic [SIZE-1:0] MDB_out;
   logic            instr_valid;
   logic [SIZE-1:0] instr;
   logic [SIZE-1:0] instr_pc;
   logic            instr_ready;
   logic [CW-1:0]   count;

   always #5 clk = ~clk;

   fetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .RST_VEC(RST_VEC), .flush(flush), .flush_addr(flush_addr),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_en(fetch_en), .MDB_out(MDB_out),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .count(count)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int issue_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [SIZE-1:0] mem_f(input logic [SIZE-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'hA5C3;
   endfunction

   // memory: answers an issued fetch one cycle later, noise otherwise
   logic            mem_iss = 1'b0;
   logic [SIZE-1:0] mem_addr = '0;
   always @(posedge clk)
      MDB_out <= mem_iss ? mem_f(mem_addr) : SIZE'($urandom);

   // occupancy/bus model from the fetch rules
   int              cnt_m = 0;
   logic            inf_m = 1'b0;
   logic [SIZE-1:0] fpc_m = '0;
   logic            model_ok = 1'b0;
   logic            req_m;
   assign req_m = !rst && !flush && ((cnt_m + int'(inf_m)) < DEPTH);

   always @(posedge clk) begin
      if (rst) begin
         model_ok <= 1'b1;
         fpc_m    <= {RST_VEC[SIZE-1:1], 1'b0};
         cnt_m    <= 0;
         inf_m    <= 1'b0;
      end else if (flush) begin
         fpc_m <= {flush_addr[SIZE-1:1], 1'b0};
         cnt_m <= 0;
         inf_m <= 1'b0;
      end else begin
         cnt_m <= cnt_m + int'(inf_m) - ((cnt_m != 0 && instr_ready) ? 1 : 0);
         inf_m <= req_m && fetch_en;
         if (req_m && fetch_en) fpc_m <= fpc_m + 16'd2;
      end
   end

   // scoreboard: the decoder must see consecutive word addresses from the last redirect
   logic [SIZE-1:0] exp_q[$];
   logic [SIZE-1:0] next_pc = '0;

   initial begin
      logic [SIZE-1:0] pc;
      forever begin
         @(negedge clk);
         #2;
         mem_iss  = fetch_req && fetch_en;
         mem_addr = fetch_addr;
         if (fetch_req && fetch_en) issue_cnt++;
         if (model_ok) begin
            chk("fetch_req", 32'(fetch_req), 32'(req_m));
            chk("fetch_addr", 32'(fetch_addr), 32'(fpc_m));
            chk("count", 32'(count), 32'(cnt_m));
            chk("instr_valid", 32'(instr_valid), 32'(cnt_m != 0));
         end
         if (instr_valid && instr_ready && !flush && !rst) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL pop_unexpected: pc %h with empty scoreboard", instr_pc);
            end else begin
               pc = exp_q.pop_front();
               chk("instr_pc", 32'(instr_pc), 32'(pc));
               chk("instr", 32'(instr), 32'(mem_f(pc)));
            end
         end
         if (rst) begin
            exp_q.delete();
            next_pc = {RST_VEC[SIZE-1:1], 1'b0};
         end else if (flush) begin
            exp_q.delete();
            next_pc = {flush_addr[SIZE-1:1], 1'b0};
         end
         while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 16'd2;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush_addr = '0; RST_VEC = 16'hC000;
      fetch_en = 1'b1; instr_ready = 1'b1;
      step(); step();
      chk("rst_fetch_req", 32'(fetch_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_fetch_addr", 32'(fetch_addr), 32'hC000);
      rst = 1'b0;
      step();
      chk("seq_addr1", 32'(fetch_addr), 32'hC002);
      chk("lat_valid_n1", 32'(instr_valid), 32'd0);
      step();
      chk("seq_addr2", 32'(fetch_addr), 32'hC004);
      chk("lat_valid_n2", 32'(instr_valid), 32'd1);
      chk("first_pc", 32'(instr_pc), 32'hC000);
      chk("first_instr", 32'(instr), 32'(mem_f(16'hC000)));

      // backpressure from an empty queue
      instr_ready = 1'b0; flush = 1'b1; flush_addr = 16'h1000;
      step();
      flush = 1'b0; issue_cnt = 0;
      repeat (8) step();
      chk("bp_issues", 32'(issue_cnt), 32'd4);
      chk("bp_count", 32'(count), 32'd4);
      chk("bp_req_low", 32'(fetch_req), 32'd0);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      repeat (4) step();
      chk("bp_one_more", 32'(issue_cnt), 32'd5);
      chk("bp_count_refill", 32'(count), 32'd4);

      // flush with count=2 and one word in flight
      instr_ready = 1'b1; fetch_en = 1'b0;
      step(); step();
      chk("fl_count_pre", 32'(count), 32'd2);
      instr_ready = 1'b0; fetch_en = 1'b1;
      step();
      chk("fl_count_inflight", 32'(count), 32'd2);
      flush = 1'b1; flush_addr = 16'hE011;
      step();
      chk("fl_count0", 32'(count), 32'd0);
      chk("fl_valid0", 32'(instr_valid), 32'd0);
      chk("fl_addr", 32'(fetch_addr), 32'hE010);
      flush = 1'b0; instr_ready = 1'b1;
      step();
      chk("fl_dropped", 32'(instr_valid), 32'd0);
      step();
      chk("fl_valid", 32'(instr_valid), 32'd1);
      chk("fl_pc", 32'(instr_pc), 32'hE010);

      // address wrap
      flush = 1'b1; flush_addr = 16'hFFFC;
      step();
      flush = 1'b0;
      chk("wr_addr0", 32'(fetch_addr), 32'hFFFC);
      step();
      chk("wr_addr1", 32'(fetch_addr), 32'hFFFE);
      step();
      chk("wr_addr2", 32'(fetch_addr), 32'h0000);
      chk("wr_pc0", 32'(instr_pc), 32'hFFFC);
      step();
      chk("wr_pc1", 32'(instr_pc), 32'hFFFE);
      step();
      chk("wr_pc2", 32'(instr_pc), 32'h0000);

      // grant toggling
      for (int i = 0; i < 12; i++) begin
         fetch_en = (i % 2 == 0);
         step();
      end
      fetch_en = 1'b1;

      // reset pulse at count=3 with a word in flight
      flush = 1'b1; flush_addr = 16'h2000; instr_ready = 1'b0;
      step();
      flush = 1'b0;
      repeat (4) step();
      chk("rp_count3", 32'(count), 32'd3);
      rst = 1'b1; RST_VEC = 16'h4001;
      step();
      chk("rp_count0", 32'(count), 32'd0);
      chk("rp_valid0", 32'(instr_valid), 32'd0);
      chk("rp_addr", 32'(fetch_addr), 32'h4000);
      rst = 1'b0; instr_ready = 1'b1;
      step();
      chk("rp_stale", 32'(instr_valid), 32'd0);
      step();
      chk("rp_pc", 32'(instr_pc), 32'h4000);

      // random traffic
      repeat (400) begin
         fetch_en    = ($urandom_range(0, 3) != 0);
         instr_ready = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         flush_addr  = SIZE'($urandom);
         rst         = ($urandom_range(0, 59) == 0);
         if (rst) RST_VEC = SIZE'($urandom);
         step();
      end
      rst = 1'b0; flush = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
